simon_block_sequencer: RTL

Sequencer between the 512-bit UART receive buffer and a single 64-bit SIMON cipher core. On a debounced go tick with a full buffer, it does three things: snapshots the 512-bit buffer, streams its eight 64-bit blocks through the core one at a time with a start/done handshake, and reassembles the results into a 512-bit word. That word is then presented to the UART transmit side until acknowledged. It replaces the direct buffer-to-buffer loopback in the top level.

---
 rtl/simon_block_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/simon_block_sequencer.sv
// simon_block_sequencer
// Takes a full 512-bit receive word, pushes its eight 64-bit blocks one at a
// time through a single SIMON core using a start/done handshake, and puts the
// per-block results back together into one 512-bit result word. The result is
// presented to the transmit side until it is acknowledged. Block k (0 = first
// received characters) sits at bits [DATA_W-1-k*BLK_W -: BLK_W] in both words.
module simon_block_sequencer #(
    parameter int BLOCKS  = 8,
    parameter int BLK_W   = 64,
    parameter int TIMEOUT = 1024,
    parameter int DATA_W  = BLOCKS * BLK_W
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      mode,
    input  logic                      buf_full,
    input  logic [DATA_W-1:0]         buf_data,
    output logic                      core_start,
    output logic                      core_decrypt,
    output logic [BLK_W-1:0]          core_in,
    input  logic                      core_done,
    input  logic [BLK_W-1:0]          core_out,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    input  logic                      result_ack,
    output logic                      busy,
    output logic [$clog2(BLOCKS)-1:0] block_idx,
    output logic                      err
);

    localparam int IDX_W = $clog2(BLOCKS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] STORE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]        state;
    logic [DATA_W-1:0] snap;      // copy of buf_data taken in LOAD
    logic [BLK_W-1:0]  out_hold;  // core_out captured on the core_done pulse
    logic [CNT_W-1:0]  tmo_cnt;   // cycles spent in WAIT for the current block
    logic              mode_lat;  // mode captured together with go

    // Extract block k of a buffer-width word; block 0 is the most significant.
    function automatic logic [BLK_W-1:0] block_of(input logic [DATA_W-1:0] word,
                                                  input int k);
        return word[DATA_W-1-k*BLK_W -: BLK_W];
    endfunction

    // Data-only capture registers: the snapshot of the receive buffer and the
    // core result. Neither needs a reset; they are only read after being written.
    always_ff @(posedge clk_100MHz) begin
        if (state == LOAD)
            snap <= buf_data;
        if (state == WAIT && core_done)
            out_hold <= core_out;
    end

    // Sequencer FSM and all registered outputs. The next core_start and core_in
    // are set on the edge that enters ISSUE so both are valid during ISSUE.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            core_in      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            block_idx    <= '0;
            err          <= 1'b0;
            tmo_cnt      <= '0;
            mode_lat     <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    // A go without a complete buffer is dropped.
                    if (go && buf_full) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        mode_lat <= mode;
                    end
                end
                LOAD: begin
                    // The snapshot register loads on this same edge, so block 0
                    // is taken straight from buf_data.
                    core_decrypt <= mode_lat;
                    block_idx    <= '0;
                    err          <= 1'b0;
                    result       <= '0;
                    core_in      <= block_of(buf_data, 0);
                    core_start   <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        state <= STORE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        // Core never answered: abandon the pass, no result.
                        state <= IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                STORE: begin
                    result[DATA_W-1-int'(block_idx)*BLK_W -: BLK_W] <= out_hold;
                    if (block_idx == LAST_IDX) begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        block_idx  <= block_idx + IDX_W'(1);
                        core_in    <= block_of(snap, int'(block_idx) + 1);
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                DONE: begin
                    // go is deliberately not looked at here; only the ack ends DONE.
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
